// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared constants and enumerations for the multi-cycle RV32M divider.
//   XLEN    : architectural register width
//   ITER    : number of restoring iterations per operation (equals XLEN)
//   op_e    : DIV / DIVU / REM / REMU encoding as presented on the op port
//   state_e : sequencer states
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int XLEN = 32;
    localparam int ITER = XLEN;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } state_e;

    // op[0] clear means the signed variant (DIV / REM)
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // op[1] set means the remainder is requested (REM / REMU)
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
// Ports:
//   rem_i     : current partial remainder (always < divisor between steps)
//   q_msb_i   : dividend/quotient bit shifted into the remainder this step
//   divisor_i : divisor magnitude
//   rem_o     : partial remainder after the step
//   q_bit_o   : quotient bit produced by the step
// The shifted remainder is WIDTH+1 bits wide so that the MSB of the trial
// difference is the borrow: rem' < 2*divisor, hence a non-negative
// difference is < 2^WIDTH and a negative one sets bit WIDTH.
// ---------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             q_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           borrow;

    always_comb begin
        shifted = {rem_i, q_msb_i};
        // a + ~b + 1 over WIDTH+1 bits
        diff    = shifted + ~{1'b0, divisor_i} + {{WIDTH{1'b0}}, 1'b1};
        borrow  = diff[WIDTH];
        rem_o   = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        q_bit_o = ~borrow;
    end

endmodule

// File: rtl/div_seq_32.sv
// ---------------------------------------------------------------------------
// div_seq_32
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer. One restoring step per clock
// through a shared div_step datapath; busy stalls the core until done pulses.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : request, sampled only while idle
//   op       : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend : rs1, captured on accept
//   divisor  : rs2, captured on accept
//   busy     : operation in progress
//   done     : one-cycle pulse, result valid
//   result   : quotient or remainder, held until next done or reset
// Build option:
//   DIV_SEQ_FAST_EN : divide-by-zero and signed overflow skip the CALC phase
//                     (done after 2 edges instead of 34). Results are the same.
// ---------------------------------------------------------------------------
module div_seq_32
    import div_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q;
    op_e              op_q;
    logic             sign_a_q;     // dividend negative (signed ops only)
    logic             sign_b_q;     // divisor negative (signed ops only)
    logic             div0_q;
    logic             ovf_q;
    logic [WIDTH-1:0] orig_q;       // raw dividend for the REM-by-zero result
    logic [WIDTH-1:0] quo_q;        // holds |dividend|, shifts into quotient
    logic [WIDTH-1:0] dvs_q;        // |divisor|
    logic [WIDTH-1:0] rem_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;

    // Accept-edge operand conditioning
    logic             acc_signed;
    logic             acc_neg_a;
    logic             acc_neg_b;
    logic [WIDTH-1:0] acc_abs_a;
    logic [WIDTH-1:0] acc_abs_b;
    logic             acc_div0;
    logic             acc_ovf;

    always_comb begin
        acc_signed = op_is_signed(op);
        acc_neg_a  = acc_signed & dividend[WIDTH-1];
        acc_neg_b  = acc_signed & divisor[WIDTH-1];
        acc_abs_a  = acc_neg_a ? (~dividend + 1'b1) : dividend;
        acc_abs_b  = acc_neg_b ? (~divisor + 1'b1) : divisor;
        acc_div0   = (divisor == '0);
        acc_ovf    = acc_signed && (dividend == MIN_NEG) && (divisor == '1);
    end

    // Shared restoring step
    logic [WIDTH-1:0] rem_d;
    logic             qbit_d;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .q_msb_i   (quo_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (rem_d),
        .q_bit_o   (qbit_d)
    );

    // Final fixups: divide-by-zero wins over overflow, which wins over sign
    // correction. Sign flags are only ever set for signed ops, so unsigned
    // results pass through untouched.
    logic [WIDTH-1:0] result_d;

    always_comb begin
        result_d = '0;
        if (div0_q) begin
            result_d = op_is_rem(op_q) ? orig_q : '1;
        end else if (ovf_q) begin
            result_d = op_is_rem(op_q) ? '0 : MIN_NEG;
        end else if (op_is_rem(op_q)) begin
            result_d = sign_a_q ? (~rem_q + 1'b1) : rem_q;
        end else begin
            result_d = (sign_a_q ^ sign_b_q) ? (~quo_q + 1'b1) : quo_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_DIV;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            orig_q   <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q     <= op_e'(op);
                        sign_a_q <= acc_neg_a;
                        sign_b_q <= acc_neg_b;
                        div0_q   <= acc_div0;
                        ovf_q    <= acc_ovf;
                        orig_q   <= dividend;
                        quo_q    <= acc_abs_a;
                        dvs_q    <= acc_abs_b;
                        rem_q    <= '0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
`ifdef DIV_SEQ_FAST_EN
                        state_q  <= (acc_div0 || acc_ovf) ? FIN : CALC;
`else
                        state_q  <= CALC;
`endif
                    end
                end
                CALC: begin
                    rem_q   <= rem_d;
                    quo_q   <= {quo_q[WIDTH-2:0], qbit_d};
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_STEP) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    result_q <= result_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
